// File: rtl/zx_kbd_pkg.sv
// Shared constants for the ZX Spectrum keyboard path: matrix coordinates,
// composite-key codes, prefix FSM states and the lookup result record.
package zx_kbd_pkg;

  localparam logic [2:0] ROW_CS_V = 3'd0;  // A8:  CS Z X C V
  localparam logic [2:0] ROW_A_G  = 3'd1;  // A9:  A S D F G
  localparam logic [2:0] ROW_Q_T  = 3'd2;  // A10: Q W E R T
  localparam logic [2:0] ROW_1_5  = 3'd3;  // A11: 1 2 3 4 5
  localparam logic [2:0] ROW_0_6  = 3'd4;  // A12: 0 9 8 7 6
  localparam logic [2:0] ROW_P_Y  = 3'd5;  // A13: P O I U Y
  localparam logic [2:0] ROW_EN_H = 3'd6;  // A14: ENTER L K J H
  localparam logic [2:0] ROW_SP_B = 3'd7;  // A15: SPACE SS M N B

  localparam logic [2:0] COL_0 = 3'd0;
  localparam logic [2:0] COL_1 = 3'd1;
  localparam logic [2:0] COL_2 = 3'd2;
  localparam logic [2:0] COL_3 = 3'd3;
  localparam logic [2:0] COL_4 = 3'd4;

  localparam logic [2:0] COMP_NONE  = 3'd0;
  localparam logic [2:0] COMP_LEFT  = 3'd1;
  localparam logic [2:0] COMP_DOWN  = 3'd2;
  localparam logic [2:0] COMP_UP    = 3'd3;
  localparam logic [2:0] COMP_RIGHT = 3'd4;
  localparam logic [2:0] COMP_BKSP  = 3'd5;
  localparam int         NUM_COMP   = 5;

  localparam logic [7:0] CODE_E0  = 8'hE0;
  localparam logic [7:0] CODE_E1  = 8'hE1;
  localparam logic [7:0] CODE_BAT = 8'hAA;
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXT  = 2'd1,
    ST_SKIP = 2'd2
  } kbd_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] comp;
  } kbd_map_t;

  function automatic kbd_map_t map_key(input logic [2:0] r, input logic [2:0] c);
    return '{valid: 1'b1, row: r, col: c, comp: COMP_NONE};
  endfunction

  function automatic kbd_map_t map_comp(input logic [2:0] cp);
    return '{valid: 1'b1, row: 3'd0, col: 3'd0, comp: cp};
  endfunction

  // Digit key that each composite pairs with CAPS SHIFT, as {row, col}.
  function automatic logic [5:0] comp_target(input logic [2:0] cp);
    case (cp)
      COMP_LEFT:  return {ROW_1_5, COL_4};
      COMP_DOWN:  return {ROW_0_6, COL_4};
      COMP_UP:    return {ROW_0_6, COL_3};
      COMP_RIGHT: return {ROW_0_6, COL_2};
      default:    return {ROW_0_6, COL_0};
    endcase
  endfunction

endpackage

// File: rtl/keyboard_map.sv
// Combinational PS/2 set-2 scancode to ZX matrix lookup. Extended (E0) codes
// use a separate small table; anything not listed comes back with valid=0.
module keyboard_map
  import zx_kbd_pkg::*;
(
  input  logic       ext_i,
  input  logic [7:0] code_i,
  output kbd_map_t   map_o
);

  always_comb begin
    map_o = '0;
    if (ext_i) begin
      case (code_i)
        8'h75:   map_o = map_comp(COMP_UP);
        8'h72:   map_o = map_comp(COMP_DOWN);
        8'h6B:   map_o = map_comp(COMP_LEFT);
        8'h74:   map_o = map_comp(COMP_RIGHT);
        8'h5A:   map_o = map_key(ROW_EN_H, COL_0);
        8'h14:   map_o = map_key(ROW_SP_B, COL_1);
        default: map_o = '0;
      endcase
    end else begin
      case (code_i)
        8'h12, 8'h59: map_o = map_key(ROW_CS_V, COL_0);
        8'h1A: map_o = map_key(ROW_CS_V, COL_1);
        8'h22: map_o = map_key(ROW_CS_V, COL_2);
        8'h21: map_o = map_key(ROW_CS_V, COL_3);
        8'h2A: map_o = map_key(ROW_CS_V, COL_4);
        8'h1C: map_o = map_key(ROW_A_G, COL_0);
        8'h1B: map_o = map_key(ROW_A_G, COL_1);
        8'h23: map_o = map_key(ROW_A_G, COL_2);
        8'h2B: map_o = map_key(ROW_A_G, COL_3);
        8'h34: map_o = map_key(ROW_A_G, COL_4);
        8'h15: map_o = map_key(ROW_Q_T, COL_0);
        8'h1D: map_o = map_key(ROW_Q_T, COL_1);
        8'h24: map_o = map_key(ROW_Q_T, COL_2);
        8'h2D: map_o = map_key(ROW_Q_T, COL_3);
        8'h2C: map_o = map_key(ROW_Q_T, COL_4);
        8'h16: map_o = map_key(ROW_1_5, COL_0);
        8'h1E: map_o = map_key(ROW_1_5, COL_1);
        8'h26: map_o = map_key(ROW_1_5, COL_2);
        8'h25: map_o = map_key(ROW_1_5, COL_3);
        8'h2E: map_o = map_key(ROW_1_5, COL_4);
        8'h45: map_o = map_key(ROW_0_6, COL_0);
        8'h46: map_o = map_key(ROW_0_6, COL_1);
        8'h3E: map_o = map_key(ROW_0_6, COL_2);
        8'h3D: map_o = map_key(ROW_0_6, COL_3);
        8'h36: map_o = map_key(ROW_0_6, COL_4);
        8'h4D: map_o = map_key(ROW_P_Y, COL_0);
        8'h44: map_o = map_key(ROW_P_Y, COL_1);
        8'h43: map_o = map_key(ROW_P_Y, COL_2);
        8'h3C: map_o = map_key(ROW_P_Y, COL_3);
        8'h35: map_o = map_key(ROW_P_Y, COL_4);
        8'h5A: map_o = map_key(ROW_EN_H, COL_0);
        8'h4B: map_o = map_key(ROW_EN_H, COL_1);
        8'h42: map_o = map_key(ROW_EN_H, COL_2);
        8'h3B: map_o = map_key(ROW_EN_H, COL_3);
        8'h33: map_o = map_key(ROW_EN_H, COL_4);
        8'h29: map_o = map_key(ROW_SP_B, COL_0);
        8'h14: map_o = map_key(ROW_SP_B, COL_1);
        8'h3A: map_o = map_key(ROW_SP_B, COL_2);
        8'h31: map_o = map_key(ROW_SP_B, COL_3);
        8'h32: map_o = map_key(ROW_SP_B, COL_4);
        8'h66: map_o = map_comp(COMP_BKSP);
        default: map_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/keyboard_matrix.sv
// PS/2 scancode events to ZX Spectrum 8x5 key matrix: E0/E1 prefix FSM,
// key/composite state registers and the active-low port-FE row read mux.
module keyboard_matrix
  import zx_kbd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       strb,
  input  logic       make,
  input  logic [7:0] code,
  input  logic [7:0] a,
  output logic [4:0] q,
  output logic       busy
);

  kbd_state_e          state_q;
  logic [2:0]          skip_q;
  logic                busy_q;
  logic [7:0][4:0]     base_q;   // 0 = held, matches bus polarity
  logic [NUM_COMP:1]   comp_q;   // 1 = composite key held
  logic [7:0][4:0]     eff;
  logic [7:0][4:0]     row_sel;
  logic [5:0]          tgt;
  kbd_map_t            lk;

  keyboard_map u_map (
    .ext_i  (state_q == ST_EXT),
    .code_i (code),
    .map_o  (lk)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
      busy_q  <= 1'b0;
      base_q  <= '1;
      comp_q  <= '0;
    end else if (ce && strb) begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          if (code == CODE_E0) begin
            state_q <= ST_EXT;
          end else if (code == CODE_E1) begin
            state_q <= ST_SKIP;
            skip_q  <= SKIP_LEN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            // BAT OK after a keyboard self-test: nothing can still be held.
            if (state_q == ST_IDLE && code == CODE_BAT) begin
              base_q <= '1;
              comp_q <= '0;
            end else if (lk.valid) begin
              if (lk.comp == COMP_NONE) base_q[lk.row][lk.col] <= make;
              else                      comp_q[lk.comp] <= ~make;
            end
          end
        end
        ST_SKIP: begin
          skip_q <= skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Composites overlay CS and their digit without touching the real-key bits.
  always_comb begin
    eff = base_q;
    tgt = '0;
    if (|comp_q) eff[ROW_CS_V][COL_0] = 1'b0;
    for (int i = 1; i <= NUM_COMP; i++) begin
      if (comp_q[i]) begin
        tgt = comp_target(3'(i));
        eff[tgt[5:3]][tgt[2:0]] = 1'b0;
      end
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    assign row_sel[gi] = a[gi] ? 5'h1F : eff[gi];
  end

  always_comb begin
    q = 5'h1F;
    for (int r = 0; r < 8; r++) q = q & row_sel[r];
  end

  assign busy = busy_q;

endmodule
